// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - store-and-forward packet FIFO; a packet is released only once its TLAST beat is stored
// Optional PKT_FIFO_DROP_EN: overflowing packets are discarded (and counted) instead of backpressuring the source.

module pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_TDATA,
  input  logic                  src_TVALID,
  input  logic                  src_TLAST,
  output logic                  src_TREADY,
  output logic [DATA_WIDTH-1:0] res_TDATA,
  output logic                  res_TVALID,
  output logic                  res_TLAST,
  input  logic                  res_TREADY,
`ifdef PKT_FIFO_DROP_EN
  output logic [15:0]           drop_cnt,
`endif
  output logic [DEPTH_LOG2:0]   pkt_cnt
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DATA_WIDTH:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          full;
  logic          accept;
  logic          wr_en;
  logic          commit_ev;
  logic          rd_fire;
  logic          rd_last_fire;

`ifdef PKT_FIFO_DROP_EN
  logic          drop_q, drop_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

`ifdef PKT_FIFO_DROP_EN
  assign src_TREADY = !rst;
  assign drop_cnt   = drop_cnt_q;
`else
  assign src_TREADY = !full && !rst;
`endif

  assign accept       = src_TVALID && src_TREADY;
  assign res_TVALID   = !rst && (rd_ptr_q != commit_ptr_q);
  assign {res_TLAST, res_TDATA} = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign rd_fire      = res_TVALID && res_TREADY;
  assign rd_last_fire = rd_fire && res_TLAST;
  assign pkt_cnt      = pkt_cnt_q;

  // Write side: store beats, commit on TLAST, or (drop build) discard an overflowing packet.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    commit_ev    = 1'b0;
`ifdef PKT_FIFO_DROP_EN
    drop_d       = drop_q;
    drop_cnt_d   = drop_cnt_q;
    if (accept) begin
      if (drop_q || full) begin
        if (src_TLAST) begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b0;
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else begin
          drop_d = 1'b1;
        end
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (src_TLAST) begin
          commit_ptr_d = wr_ptr_q + 1'b1;
          commit_ev    = 1'b1;
        end
      end
    end
`else
    if (accept) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (src_TLAST) begin
        commit_ptr_d = wr_ptr_q + 1'b1;
        commit_ev    = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({commit_ev, rd_last_fire})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
`ifdef PKT_FIFO_DROP_EN
      drop_q       <= 1'b0;
      drop_cnt_q   <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
`ifdef PKT_FIFO_DROP_EN
      drop_q       <= drop_d;
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  // wr_en is already gated by reset through src_TREADY.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {src_TLAST, src_TDATA};
    end
  end

endmodule

// File: doc/pkt_fifo.md
PKT_FIFO -- requirements
Module: pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of TDATA.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, storage depth = 2^DEPTH_LOG2 beats.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports src_TDATA/src_TVALID/src_TLAST  input  DATA_WIDTH/1/1  AXI-Stream sink, fed by the last star_arb stage's res_* bus.
REQ-006 SHALL have port src_TREADY  output  1  sink ready.
REQ-007 SHALL have ports res_TDATA/res_TVALID/res_TLAST  output  DATA_WIDTH/1/1  AXI-Stream source.
REQ-008 SHALL have port res_TREADY  input  1  downstream ready.
REQ-009 SHALL have port pkt_cnt  output  DEPTH_LOG2+1  number of complete packets stored.

Function
REQ-010 SHALL be store-and-forward: no beat of a packet is presented on res_* until that packet's TLAST beat has been written.
REQ-011 SHALL store {TLAST, TDATA} per beat; beat accepted when src_TVALID && src_TREADY at a rising edge.
REQ-012 SHALL keep wr_ptr, commit_ptr, rd_ptr, each DEPTH_LOG2+1 bits, wrapping modulo 2^(DEPTH_LOG2+1); address = low DEPTH_LOG2 bits.
REQ-013 SHALL define full = (wr_ptr - rd_ptr) == 2^DEPTH_LOG2; src_TREADY = !full && !rst (combinational).
REQ-014 SHALL advance wr_ptr by 1 per accepted beat; on an accepted TLAST beat, commit_ptr <= wr_ptr + 1 on the same edge.
REQ-015 SHALL drive res_TVALID = (rd_ptr != commit_ptr); res_TDATA/res_TLAST = stored beat at rd_ptr.
REQ-016 SHALL, for a TLAST beat accepted at edge N, assert res_TVALID in the cycle after edge N (1-cycle minimum latency) if no older packets are pending.
REQ-017 SHALL advance rd_ptr by 1 when res_TVALID && res_TREADY.
REQ-018 SHALL hold res_TDATA/res_TLAST stable while res_TVALID && !res_TREADY.
REQ-019 SHALL update pkt_cnt: +1 on commit, -1 on res TLAST handshake, unchanged when both occur on the same edge.
REQ-020 SHALL, when full, accept no write even if a read occurs on the same edge (no pass-through); src_TREADY rises the cycle after the read.
REQ-021 SHALL treat a TLAST beat arriving into the final free slot as a normal commit (full and committed together).

Reset
REQ-022 SHALL, while rst is high at an edge, set wr_ptr, commit_ptr, rd_ptr, pkt_cnt to 0; partial and committed packets are discarded.
REQ-023 SHALL hold res_TVALID = 0 and src_TREADY = 0 while rst is high; src_TREADY = 1 in the first cycle after rst falls.
REQ-024 SHALL make reset mid-packet (either side) abandon the packet; no beat of it appears after reset.

Configuration
REQ-025 SHALL honour macro PKT_FIFO_DROP_EN.
REQ-026 Without PKT_FIFO_DROP_EN: packets longer than 2^DEPTH_LOG2 beats are illegal (deadlock permitted); full backpressures per REQ-013.
REQ-027 With PKT_FIFO_DROP_EN: src_TREADY = !rst only; a beat arriving when full sets a drop flag and is discarded; remaining beats of that packet are discarded; on its TLAST, wr_ptr <= commit_ptr, drop flag clears, no commit.
REQ-028 With PKT_FIFO_DROP_EN: SHALL add output drop_cnt, 16 bits, reset 0, +1 per dropped packet, saturating at 0xFFFF.

Verification
REQ-029 Reset then 3-beat packet 0x01,0x05,0x09 (TLAST on 3rd), res_TREADY=1 -> res_TVALID low until cycle after 3rd beat, then 0x01,0x05,0x09 on consecutive cycles, TLAST on 0x09; pkt_cnt 0->1->0.
REQ-030 DEPTH_LOG2=2, res_TREADY=0, two 2-beat packets -> src_TREADY low after 4th beat, pkt_cnt=2; res_TREADY=1 one cycle -> src_TREADY high next cycle.
REQ-031 Commit and TLAST read on same edge -> pkt_cnt unchanged (e.g. stays 1).
REQ-032 rst pulsed after 2 beats of a 4-beat packet -> res_TVALID stays 0; next packet emerges intact.
REQ-033 PKT_FIFO_DROP_EN, DEPTH_LOG2=2, res_TREADY=0, 6-beat packet then 2-beat packet 0xA0,0xA1 -> first dropped, drop_cnt=1, then 0xA0,0xA1 output when res_TREADY=1.
REQ-034 Random VALID/READY from 4 chained star_arb sources for 5000 cycles -> output packets bit-exact in arrival order, none split or interleaved.
